// File: rtl/spi_regmap_bridge.sv
// SPI mode-0 slave that converts host frames (command byte + data bytes) into
// register-bus read/write accesses, with burst addressing and MISO read-back.
module spi_regmap_bridge #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  write_en_o,
    output logic                  read_en_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    output logic                  abort_o
);
    localparam int CMD_BITS = ADDR_WIDTH + 1;
    localparam int SHIFT_W  = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
    localparam int CNT_W    = $clog2(SHIFT_W + 1);
    localparam int ACC_W    = $clog2(ACC_CYCLES + 1);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACC_CYCLES - 1);
    localparam logic [ACC_W-1:0] ACC_DONE  = ACC_W'(ACC_CYCLES);
    // Bit order {sclk, cs_n, mosi}; cs_n settles high so reset looks deselected.
    localparam logic [2:0] SYNC_INIT = 3'b010;

    typedef enum logic [2:0] {IDLE, CMD, RD_ACC, DATA, WR_ACC} state_t;

    logic [2:0] pad_vec;
    logic [2:0] sync_vec;
    assign pad_vec = {sclk_i, cs_n_i, mosi_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic meta_reg;
        logic stable_reg;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                meta_reg   <= SYNC_INIT[gi];
                stable_reg <= SYNC_INIT[gi];
            end else begin
                meta_reg   <= pad_vec[gi];
                stable_reg <= meta_reg;
            end
        end
        assign sync_vec[gi] = stable_reg;
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_d_reg;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_s    = sync_vec[2];
    assign cs_s      = sync_vec[1];
    assign mosi_s    = sync_vec[0];
    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_d_reg <= 1'b0;
        end else begin
            sclk_d_reg <= sclk_s;
        end
    end

    state_t                state_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [ACC_W-1:0]      acc_cnt_reg;
    logic [SHIFT_W-2:0]    shift_reg;
    logic [SHIFT_W-1:0]    shift_next;
    logic [DATA_WIDTH-1:0] tx_reg;
    logic                  is_read_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] write_data_reg;
    logic                  write_en_reg;
    logic                  read_en_reg;
    logic                  abort_reg;
    logic                  miso_reg;
    logic                  miso_oe_reg;

    assign shift_next = {shift_reg, mosi_s};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            acc_cnt_reg    <= '0;
            shift_reg      <= '0;
            tx_reg         <= '0;
            is_read_reg    <= 1'b0;
            addr_reg       <= '0;
            write_data_reg <= '0;
            write_en_reg   <= 1'b0;
            read_en_reg    <= 1'b0;
            abort_reg      <= 1'b0;
            miso_reg       <= 1'b0;
            miso_oe_reg    <= 1'b0;
        end else begin
            abort_reg   <= 1'b0;
            miso_oe_reg <= ~cs_s;
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg  <= '0;
                    miso_reg     <= 1'b0;
                    write_en_reg <= 1'b0;
                    read_en_reg  <= 1'b0;
                    if (!cs_s) begin
                        state_reg <= CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise && bit_cnt_reg == CMD_LAST) begin
                        addr_reg    <= shift_next[ADDR_WIDTH-1:0];
                        is_read_reg <= shift_next[ADDR_WIDTH];
                        bit_cnt_reg <= '0;
                        acc_cnt_reg <= '0;
                        if (shift_next[ADDR_WIDTH]) begin
                            read_en_reg <= 1'b1;
                            state_reg   <= RD_ACC;
                        end else begin
                            state_reg <= DATA;
                        end
                    end else if (cs_s) begin
                        abort_reg <= (bit_cnt_reg != '0) || sclk_rise;
                        state_reg <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg   <= shift_next[SHIFT_W-2:0];
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    // A final rise wins over a simultaneous deselect: the byte is complete.
                    if (sclk_rise && bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_reg <= '0;
                        acc_cnt_reg <= '0;
                        if (is_read_reg) begin
                            addr_reg    <= addr_reg + ADDR_WIDTH'(1);
                            read_en_reg <= 1'b1;
                            state_reg   <= RD_ACC;
                        end else begin
                            write_data_reg <= shift_next[DATA_WIDTH-1:0];
                            write_en_reg   <= 1'b1;
                            state_reg      <= WR_ACC;
                        end
                    end else if (cs_s) begin
                        abort_reg <= (bit_cnt_reg != '0) || sclk_rise;
                        state_reg <= IDLE;
                    end else if (sclk_rise) begin
                        shift_reg   <= shift_next[SHIFT_W-2:0];
                        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    end else if (sclk_fall && is_read_reg && bit_cnt_reg != '0) begin
                        // The fall that trails a byte boundary has nothing new to shift.
                        tx_reg   <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
                        miso_reg <= tx_reg[DATA_WIDTH-2];
                    end
                end
                RD_ACC: begin
                    acc_cnt_reg <= acc_cnt_reg + ACC_W'(1);
                    if (acc_cnt_reg == ACC_LAST) begin
                        read_en_reg <= 1'b0;
                    end
                    if (acc_cnt_reg == ACC_DONE) begin
                        tx_reg <= read_data_i;
                        if (cs_s) begin
                            miso_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            miso_reg  <= read_data_i[DATA_WIDTH-1];
                            state_reg <= DATA;
                        end
                    end
                end
                WR_ACC: begin
                    acc_cnt_reg <= acc_cnt_reg + ACC_W'(1);
                    if (acc_cnt_reg == ACC_LAST) begin
                        write_en_reg <= 1'b0;
                        addr_reg     <= addr_reg + ADDR_WIDTH'(1);
                        state_reg    <= cs_s ? IDLE : DATA;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign miso_o       = miso_reg;
    assign miso_oe_o    = miso_oe_reg;
    assign addr_o       = addr_reg;
    assign write_data_o = write_data_reg;
    assign write_en_o   = write_en_reg;
    assign read_en_o    = read_en_reg;
    assign abort_o      = abort_reg;
endmodule

// File: tb/tb_spi_regmap_bridge.sv
// Bench for spi_regmap_bridge: table of whole SPI frames plus hand-written
// abort and mid-access reset sequences.
module tb_spi_regmap_bridge;
    localparam int H = 12;  // SCLK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_i;
    logic       sclk_i;
    logic       cs_n_i;
    logic       mosi_i;
    logic       miso_o;
    logic       miso_oe_o;
    logic [6:0] addr_o;
    logic [7:0] write_data_o;
    logic       write_en_o;
    logic       read_en_o;
    logic [7:0] read_data_i;
    logic       abort_o;
    logic       rd_xor;

    always #5 clk = ~clk;

    spi_regmap_bridge dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .sclk_i       (sclk_i),
        .cs_n_i       (cs_n_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .miso_oe_o    (miso_oe_o),
        .addr_o       (addr_o),
        .write_data_o (write_data_o),
        .write_en_o   (write_en_o),
        .read_en_o    (read_en_o),
        .read_data_i  (read_data_i),
        .abort_o      (abort_o)
    );

    // Register map model: constant 0xCC, or address xor 0x0F.
    always_comb begin
        read_data_i = 8'hCC;
        if (rd_xor) read_data_i = {1'b0, addr_o} ^ 8'h0F;
    end

    // Access-window logger
    int         wr_n = 0;
    int         rd_n = 0;
    int         abort_cnt = 0;
    int         unstable = 0;
    logic [6:0] wr_addr_log [0:63];
    logic [7:0] wr_data_log [0:63];
    int         wr_len_log  [0:63];
    logic [6:0] rd_addr_log [0:63];
    int         rd_len_log  [0:63];
    logic       we_prev = 1'b0;
    logic       re_prev = 1'b0;
    int         we_len = 0;
    int         re_len = 0;
    logic [6:0] we_addr = '0;
    logic [7:0] we_data = '0;
    logic [6:0] re_addr = '0;

    always @(negedge clk) begin
        we_prev <= write_en_o;
        re_prev <= read_en_o;
        if (write_en_o === 1'b1 && !we_prev) begin
            we_len  <= 1;
            we_addr <= addr_o;
            we_data <= write_data_o;
        end else if (write_en_o === 1'b1) begin
            we_len <= we_len + 1;
            if (addr_o !== we_addr || write_data_o !== we_data) unstable <= unstable + 1;
        end else if (we_prev) begin
            wr_addr_log[wr_n[5:0]] <= we_addr;
            wr_data_log[wr_n[5:0]] <= we_data;
            wr_len_log[wr_n[5:0]]  <= we_len;
            wr_n <= wr_n + 1;
        end
        if (read_en_o === 1'b1 && !re_prev) begin
            re_len  <= 1;
            re_addr <= addr_o;
        end else if (read_en_o === 1'b1) begin
            re_len <= re_len + 1;
            if (addr_o !== re_addr) unstable <= unstable + 1;
        end else if (re_prev) begin
            rd_addr_log[rd_n[5:0]] <= re_addr;
            rd_len_log[rd_n[5:0]]  <= re_len;
            rd_n <= rd_n + 1;
        end
        if (abort_o === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    typedef struct packed {
        logic [7:0]      cmd;
        logic            rd_xor;
        logic [1:0]      n_bytes;
        logic [2:0][7:0] data;   // {byte2, byte1, byte0}
        logic [1:0]      n_wr;
        logic [2:0][6:0] waddr;  // {w2, w1, w0}
        logic [1:0]      n_rd;
        logic [2:0][6:0] raddr;  // {r2, r1, r0}
        logic [2:0][7:0] miso;   // expected MISO bytes {m2, m1, m0}
    } vec_t;

    vec_t vecs [0:4];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shifts the top nbits of tx, MSB first; MISO is read just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi_i = tx[7-i];
            wait_cyc(H);
            rx[7-i] = miso_o;
            sclk_i = 1'b1;
            wait_cyc(H);
            sclk_i = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_outs"}, -1,
              {19'd0, miso_o, miso_oe_o, addr_o, write_data_o, write_en_o, read_en_o, abort_o},
              32'd0);
    endtask

    task automatic apply_vec(input int idx);
        vec_t       v;
        logic [7:0] rx;
        int         wb;
        int         rb;
        int         ab;
        int         ub;
        v  = vecs[idx];
        rd_xor = v.rd_xor;
        wb = wr_n;
        rb = rd_n;
        ab = abort_cnt;
        ub = unstable;
        $display("frame vec=%0d cmd=0x%02h bytes=%0d", idx, v.cmd, v.n_bytes);
        cs_n_i = 1'b0;
        wait_cyc(H);
        check("oe_in_frame", idx, miso_oe_o, 1);
        spi_bits(v.cmd, 8, rx);
        check("miso_cmd", idx, rx, 0);
        for (int i = 0; i < int'(v.n_bytes); i++) begin
            spi_bits(v.data[i], 8, rx);
            check("miso_byte", idx, rx, v.miso[i]);
        end
        wait_cyc(H);
        cs_n_i = 1'b1;
        wait_cyc(40);
        check("oe_after", idx, miso_oe_o, 0);
        check("n_writes", idx, wr_n - wb, v.n_wr);
        for (int i = 0; i < int'(v.n_wr); i++) begin
            check("wr_addr", idx, wr_addr_log[wb + i], v.waddr[i]);
            check("wr_data", idx, wr_data_log[wb + i], v.data[i]);
            check("wr_len", idx, wr_len_log[wb + i], 3);
        end
        check("n_reads", idx, rd_n - rb, v.n_rd);
        for (int i = 0; i < int'(v.n_rd); i++) begin
            check("rd_addr", idx, rd_addr_log[rb + i], v.raddr[i]);
            check("rd_len", idx, rd_len_log[rb + i], 3);
        end
        check("no_abort", idx, abort_cnt - ab, 0);
        check("stable", idx, unstable - ub, 0);
    endtask

    initial begin
        logic [7:0] rx;
        int         wb;
        int         ab;
        logic       found;

        vecs[0] = '{cmd: 8'h01, rd_xor: 1'b0, n_bytes: 2'd1, data: {8'h00, 8'h00, 8'h5A},
                    n_wr: 2'd1, waddr: {7'h00, 7'h00, 7'h01}, n_rd: 2'd0, raddr: '0, miso: '0};
        vecs[1] = '{cmd: 8'h03, rd_xor: 1'b0, n_bytes: 2'd1, data: {8'h00, 8'h00, 8'hA5},
                    n_wr: 2'd1, waddr: {7'h00, 7'h00, 7'h03}, n_rd: 2'd0, raddr: '0, miso: '0};
        vecs[2] = '{cmd: 8'h80, rd_xor: 1'b0, n_bytes: 2'd1, data: '0,
                    n_wr: 2'd0, waddr: '0, n_rd: 2'd2, raddr: {7'h00, 7'h01, 7'h00},
                    miso: {8'h00, 8'h00, 8'hCC}};
        vecs[3] = '{cmd: 8'h7E, rd_xor: 1'b0, n_bytes: 2'd3, data: {8'h33, 8'h22, 8'h11},
                    n_wr: 2'd3, waddr: {7'h00, 7'h7F, 7'h7E}, n_rd: 2'd0, raddr: '0, miso: '0};
        vecs[4] = '{cmd: 8'h85, rd_xor: 1'b1, n_bytes: 2'd2, data: '0,
                    n_wr: 2'd0, waddr: '0, n_rd: 2'd3, raddr: {7'h07, 7'h06, 7'h05},
                    miso: {8'h00, 8'h09, 8'h0A}};

        rst_i  = 1'b1;
        sclk_i = 1'b0;
        cs_n_i = 1'b1;
        mosi_i = 1'b0;
        rd_xor = 1'b0;
        wait_cyc(5);
        rst_i = 1'b0;
        wait_cyc(3);
        check("rst_we", -1, write_en_o, 0);
        check("rst_re", -1, read_en_o, 0);
        check("rst_abort", -1, abort_o, 0);
        check("rst_oe", -1, miso_oe_o, 0);
        check("rst_miso", -1, miso_o, 0);
        check("rst_addr", -1, addr_o, 0);
        check("rst_wdata", -1, write_data_o, 0);

        // Frame cut after 5 data bits of a write
        $display("frame abort cmd=0x10 bits=5");
        wb = wr_n;
        ab = abort_cnt;
        cs_n_i = 1'b0;
        wait_cyc(H);
        spi_bits(8'h10, 8, rx);
        spi_bits(8'hC8, 5, rx);
        wait_cyc(H);
        cs_n_i = 1'b1;
        wait_cyc(40);
        check("abort_pulse", -1, abort_cnt - ab, 1);
        check("abort_no_write", -1, wr_n - wb, 0);

        for (int i = 0; i < 5; i++) apply_vec(i);

        // Reset during the second cycle of a write window
        $display("frame reset-mid-write cmd=0x20 data=0x77");
        cs_n_i = 1'b0;
        wait_cyc(H);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h77, 7, rx);
        mosi_i = 1'b1;
        wait_cyc(H);
        sclk_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            wait_cyc(1);
            if (write_en_o) found = 1'b1;
        end
        check("we_seen", -1, found, 1);
        wait_cyc(1);
        rst_i = 1'b1;
        check("we_cycle2", -1, write_en_o, 1);
        wait_cyc(1);
        check("we_drop", -1, write_en_o, 0);
        check_idle_outputs("in_reset");
        wait_cyc(H);
        sclk_i = 1'b0;
        wait_cyc(H);
        cs_n_i = 1'b1;
        wait_cyc(5);
        rst_i = 1'b0;
        wait_cyc(10);
        check_idle_outputs("post_reset");
        apply_vec(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
